mux_rr_arbiter: RTL
===================

# mux_rr_arbiter

Round-robin arbiter that shares a single `WIDTH`-bit multiplexed output channel between `N_REQ` requesters. It sits in front of the shared datapath. Each cycle it picks one valid requester, steers that requester's data through the select path into a registered output stage, and reports the winning index. All traffic uses valid/ready handshakes, and the output is registered with one cycle of latency.

## Interface
Parameters:
- `N_REQ`, 4, number of requesters (2..16)
- `WIDTH`, 4, data width per requester
- `IDW`, `$clog2(N_REQ)`, width of the grant index (derived, not overridden)

Ports:
- `clk` input 1: single clock, rising edge
- `rst` input 1: reset, synchronous and active-high
- `req_valid` input `N_REQ`: per-requester data valid
- `req_data` input `N_REQ*WIDTH`: packed data; requester i occupies bits `[i*WIDTH +: WIDTH]`
- `req_ready` output `N_REQ`: per-requester accept, one-hot or zero
- `out_valid` output 1: registered output valid
- `out_data` output `WIDTH`: registered output data
- `out_ready` input 1: downstream accept
- `out_id` output `IDW`: index of the requester whose data is in `out_data`
- `req_last` input `N_REQ`: end-of-packet flag; exists only with `MUX_ARB_LOCK_EN`

## Operation
- Load enable is `ld = !out_valid || out_ready`, so the stage loads when empty or draining.
- Winner selection:
  - The winner is the first `i` with `req_valid[i]`, scanning circularly from `ptr+1` (mod `N_REQ`).
  - `ptr` is the index of the last granted requester.
- Ready generation: `req_ready[i] = ld && (i == winner) && req_valid[i]`. At most one bit is set.
- On a transfer (any `req_ready & req_valid`):
  - `out_data` captures the winner's data.
  - `out_id` captures the winner index.
  - `out_valid` is set to 1.
  - `ptr` is set to the winner index.
- If `ld` is true and no requester is valid, `out_valid` is cleared. `out_data` and `out_id` hold their values.
- If `ld` is false, every `req_ready` is 0 and all state holds (backpressure).
- Fairness: a continuously valid requester waits at most `N_REQ-1` transfers before it is granted.
- Two-state control, `IDLE` (`out_valid=0`) and `FULL` (`out_valid=1`):
  - `IDLE`→`FULL` on a transfer.
  - `FULL`→`FULL` on `out_ready` with a transfer, or on `!out_ready`.
  - `FULL`→`IDLE` on `out_ready` with no valid requester.

## Timing
- Reset values:
  - `out_valid=0`, `out_data=0`, `out_id=0`, `req_ready=0`.
  - `ptr=N_REQ-1`, so requester 0 has first priority.
  - With `MUX_ARB_LOCK_EN`: `locked=0`.
- Latency: data is accepted at edge k and appears on `out_data`/`out_valid` after edge k.
- Throughput: one beat per cycle when `out_ready` is held high.
- `req_ready` is combinational from `req_valid`, `out_ready` and state. Requesters must not derive `req_valid` from `req_ready`.
- Simultaneous output drain and new load in one cycle is a normal single-cycle handoff with no bubble.
- Synchronous reset asserted mid-stream:
  - The held beat is discarded and `out_valid` drops after the reset edge.
  - `req_ready` is forced to 0 while `rst` is high.
- `out_valid` and `out_data` must stay stable while `out_valid && !out_ready`.

## Configuration
- Macro: `MUX_ARB_LOCK_EN`.
- Defined:
  - Adds the `req_last` port and a `locked` flag.
  - After a transfer with `req_last[winner]=0`, `locked=1` and arbitration is bypassed. Only `ptr` is eligible until a beat with `req_last=1` transfers, which clears `locked`.
  - While locked, other requesters receive no ready even if `ptr` is idle.
- Undefined: every beat is arbitrated independently, with no `req_last` port and no lock state.

## Structure
- Package `mux_arb_pkg` holds:
  - Default `N_REQ`/`WIDTH` constants.
  - The state enum `arb_state_e {IDLE, FULL}`.
  - The function computing `IDW`.
- Sub-module `rr_pick`: combinational round-robin picker.
  - Inputs: `req` vector and `ptr`.
  - Outputs: `winner` index and a `any` flag.
  - Reusable by other schedulers in the tool.
- `mux_rr_arbiter` instantiates one `rr_pick` plus the output register and control.

## Test plan
- **Reset priority:** `rst` high 2 cycles then low; `req_valid=4'b1111`, `out_ready=1` → grants 0,1,2,3,0 on consecutive cycles, and `out_id` follows one cycle later.
- **Single requester:** only `req_valid[2]=1`, `req_data` for requester 2 = 4'hA → `out_data=4'hA`, `out_id=2` every cycle. Requesters 0, 1 and 3 never see `req_ready`.
- **Backpressure:** output loaded with 4'h5, then `out_ready=0` for 3 cycles with all requesters valid → `out_data` holds 4'h5, `req_ready=0`. After `out_ready=1`, the next grant continues round-robin order.
- **Drain to idle:** `out_valid=1`, `out_ready=1`, all `req_valid=0` → `out_valid=0` next cycle and `out_data` unchanged.
- **Reset mid-stream:** `rst` pulsed while `out_valid=1` → `out_valid=0` and `out_id=0` after the edge. The first grant afterwards goes to requester 0.
- **Lock (`MUX_ARB_LOCK_EN`):** requester 1 sends 3 beats with `req_last` on the third while requester 0 stays valid → grants 1,1,1, then 2 or 0 per the round-robin scan.

Source files
------------

// File: rtl/mux_arb_pkg.sv
// Shared constants, state encoding and index-width helper for the multiplexing
// round-robin arbiter and any scheduler that reuses its picker.
package mux_arb_pkg;

  localparam int N_REQ_DEF = 4;
  localparam int WIDTH_DEF = 4;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    FULL = 1'b1
  } arb_state_e;

  // A single requester would still need a 1-bit index port.
  function automatic int calc_idw(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/mux_rr_arbiter_rr_pick.sv
// Combinational round-robin picker: first set bit of req scanning circularly
// from ptr+1, wrapping so that ptr itself is considered last.
module rr_pick
  import mux_arb_pkg::*;
#(
  parameter int N_REQ = N_REQ_DEF,
  parameter int IDW   = calc_idw(N_REQ)
) (
  input  logic [N_REQ-1:0] req,
  input  logic [IDW-1:0]   ptr,
  output logic [IDW-1:0]   winner,
  output logic             any
);

  logic [IDW-1:0] idx_s;

  // Circular priority scan starting just after the last grant.
  always_comb begin
    winner = {IDW{1'b0}};
    any    = 1'b0;
    idx_s  = {IDW{1'b0}};
    for (int k = 1; k <= N_REQ; k++) begin
      idx_s = IDW'((int'(ptr) + k) % N_REQ);
      if (!any && req[idx_s]) begin
        any    = 1'b1;
        winner = idx_s;
      end else begin
        any    = any;
      end
    end
  end

endmodule

// File: rtl/mux_rr_arbiter.sv
// Round-robin arbiter steering one of N_REQ valid/ready streams into a
// registered output stage. Define MUX_ARB_LOCK_EN for packet locking (req_last).
module mux_rr_arbiter
  import mux_arb_pkg::*;
#(
  parameter int N_REQ = N_REQ_DEF,
  parameter int WIDTH = WIDTH_DEF,
  parameter int IDW   = calc_idw(N_REQ)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [N_REQ-1:0]       req_valid,
  input  logic [N_REQ*WIDTH-1:0] req_data,
  output logic [N_REQ-1:0]       req_ready,
  output logic                   out_valid,
  output logic [WIDTH-1:0]       out_data,
  input  logic                   out_ready,
`ifdef MUX_ARB_LOCK_EN
  input  logic [N_REQ-1:0]       req_last,
`endif
  output logic [IDW-1:0]         out_id
);

  arb_state_e       state_r, state_nxt_s;
  logic [IDW-1:0]   ptr_r, out_id_r, winner_s;
  logic [WIDTH-1:0] out_data_r;
  logic [WIDTH-1:0] lane_s [N_REQ];
  logic [N_REQ-1:0] pick_req_s, req_ready_s;
  logic             any_s, ld_s, xfer_s;

`ifdef MUX_ARB_LOCK_EN
  logic             locked_r;
  logic [N_REQ-1:0] ptr_onehot_s;

  assign ptr_onehot_s = {{(N_REQ-1){1'b0}}, 1'b1} << ptr_r;
`endif

  assign ld_s = (state_r == IDLE) || out_ready;

  // While a packet is in flight only its owner may be picked; otherwise everyone.
  always_comb begin
    pick_req_s = req_valid;
`ifdef MUX_ARB_LOCK_EN
    if (locked_r) begin
      pick_req_s = req_valid & ptr_onehot_s;
    end else begin
      pick_req_s = req_valid;
    end
`endif
  end

  rr_pick #(
    .N_REQ (N_REQ),
    .IDW   (IDW)
  ) u_pick (
    .req    (pick_req_s),
    .ptr    (ptr_r),
    .winner (winner_s),
    .any    (any_s)
  );

  // Unpack the flat data bus into per-requester lanes for the select path.
  always_comb begin
    for (int i = 0; i < N_REQ; i++) begin
      lane_s[i] = req_data[i*WIDTH +: WIDTH];
    end
  end

  // One-hot accept toward the winner; suppressed under backpressure or reset.
  always_comb begin
    req_ready_s = {N_REQ{1'b0}};
    xfer_s      = 1'b0;
    if (!rst && ld_s && any_s) begin
      req_ready_s = {{(N_REQ-1){1'b0}}, 1'b1} << winner_s;
      xfer_s      = 1'b1;
    end else begin
      req_ready_s = {N_REQ{1'b0}};
      xfer_s      = 1'b0;
    end
  end

  // Output-stage occupancy: a load keeps it full, a drain with nothing to load empties it.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      IDLE: begin
        if (xfer_s) begin
          state_nxt_s = FULL;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      FULL: begin
        if (out_ready && !xfer_s) begin
          state_nxt_s = IDLE;
        end else begin
          state_nxt_s = FULL;
        end
      end
      default: state_nxt_s = IDLE;
    endcase
  end

  // Output register, grant pointer and lock flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r    <= IDLE;
      out_data_r <= {WIDTH{1'b0}};
      out_id_r   <= {IDW{1'b0}};
      ptr_r      <= IDW'(N_REQ - 1);
`ifdef MUX_ARB_LOCK_EN
      locked_r   <= 1'b0;
`endif
    end else begin
      state_r <= state_nxt_s;
      if (xfer_s) begin
        out_data_r <= lane_s[winner_s];
        out_id_r   <= winner_s;
        ptr_r      <= winner_s;
`ifdef MUX_ARB_LOCK_EN
        locked_r   <= ~req_last[winner_s];
`endif
      end else begin
        out_data_r <= out_data_r;
        out_id_r   <= out_id_r;
        ptr_r      <= ptr_r;
      end
    end
  end

  assign req_ready = req_ready_s;
  assign out_valid = (state_r == FULL);
  assign out_data  = out_data_r;
  assign out_id    = out_id_r;

endmodule
